// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg: shared widths, FSM state type and the round/saturate helper for psum_accum_wb.
package psum_accum_pkg;
    localparam int TILE_SIZE = 4;
    localparam int ACC_WIDTH = 32;
    localparam int OUT_WIDTH = 16;
    localparam int KT_W = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ACC_EXT_W = ACC_WIDTH + KT_W;
    // One extra bit over the accumulator so the rounding add can never wrap.
    localparam logic signed [ACC_EXT_W:0] OUT_MAX = (ACC_EXT_W + 1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_EXT_W:0] OUT_MIN = -OUT_MAX - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    function automatic logic signed [OUT_WIDTH-1:0] sat_round(
        input logic signed [ACC_EXT_W-1:0] value,
        input logic [4:0] shift
    );
        logic signed [ACC_EXT_W:0] t;
        logic signed [ACC_EXT_W:0] rnd;
        t = {value[ACC_EXT_W-1], value};
        rnd = (shift == 5'd0) ? '0 : signed'((ACC_EXT_W + 1)'(1) << (shift - 5'd1));
        t = (t + rnd) >>> shift;
        return (t > OUT_MAX) ? OUT_MAX[OUT_WIDTH-1:0] :
               (t < OUT_MIN) ? OUT_MIN[OUT_WIDTH-1:0] : t[OUT_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with same-cycle push/pop allowed when full.
// Ports: clk, rst (sync, active-high, empties the FIFO), push/din write side,
// pop/dout read side (dout is the head entry), full, empty.
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && !empty;
    // A pop frees the slot being written, so a full FIFO still accepts a push then.
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/psum_accum_wb.sv
// psum_accum_wb: accumulates K reduced partial-sum beats per group, requantizes and queues results.
// Ports: clk, rst (sync, active-high); start + cfg_k_tiles/cfg_n_groups/cfg_shift job config;
// valid_reduced/reduced_vec input beats (no backpressure); out_valid/out_ready/out_vec/out_last
// result stream; busy, done (one-cycle pulse at job end), overflow_err (sticky dropped result).
module psum_accum_wb
    import psum_accum_pkg::*;
#(
    parameter int TILE_SIZE = psum_accum_pkg::TILE_SIZE,
    parameter int ACC_WIDTH = psum_accum_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH = psum_accum_pkg::OUT_WIDTH,
    parameter int KT_W = psum_accum_pkg::KT_W,
    parameter int FIFO_DEPTH = psum_accum_pkg::FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [KT_W-1:0]                      cfg_k_tiles,
    input  logic [KT_W-1:0]                      cfg_n_groups,
    input  logic [4:0]                           cfg_shift,
    input  logic                                 valid_reduced,
    input  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0]  reduced_vec,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TILE_SIZE-1:0][OUT_WIDTH-1:0]  out_vec,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overflow_err
);
    localparam int FW = TILE_SIZE * OUT_WIDTH + 1;

    state_t state, state_next;
    logic [KT_W-1:0] k_cfg, n_cfg, beat, grp;
    logic [4:0] shift_cfg;
    logic signed [ACC_EXT_W-1:0] acc [TILE_SIZE];
    logic signed [ACC_EXT_W-1:0] sum [TILE_SIZE];
    logic [TILE_SIZE-1:0][OUT_WIDTH-1:0] q;
    logic [FW-1:0] dout;
    logic last_beat, last_grp, push, pop, full, empty;

    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            sum[i] = acc[i] + {{KT_W{reduced_vec[i][ACC_WIDTH-1]}}, reduced_vec[i]};
            q[i] = sat_round(sum[i], shift_cfg);
        end
    end

    assign last_beat = beat == k_cfg - 1'b1;
    assign last_grp = grp == n_cfg - 1'b1;
    assign push = state == ACCUM && valid_reduced && last_beat;
    assign pop = out_valid && out_ready;
    assign out_valid = !empty;
    // Head is masked while empty so the unwritten storage never reaches the port.
    assign out_last = !empty && dout[FW-1];
    assign out_vec = empty ? '0 : dout[FW-2:0];

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  ({last_grp, q}),
        .dout (dout),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (cfg_n_groups == '0) ? DRAIN : ACCUM;
            ACCUM:   if (push && last_grp) state_next = DRAIN;
            DRAIN:   if (empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            k_cfg <= '0;
            n_cfg <= '0;
            shift_cfg <= '0;
            beat <= '0;
            grp <= '0;
            done <= 1'b0;
            overflow_err <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
        end else begin
            done <= state == DRAIN && empty;
            if (state == IDLE && start) begin
                k_cfg <= (cfg_k_tiles == '0) ? KT_W'(1) : cfg_k_tiles;
                n_cfg <= cfg_n_groups;
                shift_cfg <= cfg_shift;
                beat <= '0;
                grp <= '0;
                overflow_err <= 1'b0;
                for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
            end else if (state == ACCUM && valid_reduced) begin
                beat <= last_beat ? '0 : beat + 1'b1;
                grp <= last_beat ? grp + 1'b1 : grp;
                for (int i = 0; i < TILE_SIZE; i++) acc[i] <= last_beat ? '0 : sum[i];
                // Dropped result; the group counter still advances so the job ends.
                if (push && full && !pop) overflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_psum_accum_wb.sv
// tb_psum_accum_wb: scenario tasks plus randomized jobs checked against a behavioural model.
module tb_psum_accum_wb;
    logic clk = 1'b0;
    logic rst, start, valid_reduced, out_ready;
    logic [7:0] cfg_k_tiles, cfg_n_groups;
    logic [4:0] cfg_shift;
    logic [3:0][31:0] reduced_vec;
    logic out_valid, out_last, busy, done, overflow_err;
    logic [3:0][15:0] out_vec;
    int checks = 0;
    int errors = 0;
    logic [64:0] got[$];

    psum_accum_wb dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k_tiles(cfg_k_tiles),
        .cfg_n_groups(cfg_n_groups), .cfg_shift(cfg_shift), .valid_reduced(valid_reduced),
        .reduced_vec(reduced_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_last(out_last), .busy(busy), .done(done),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && out_valid && out_ready) got.push_back({out_last, out_vec});

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rq(input longint s, input int sh);
        longint r;
        r = (sh > 0) ? (s + (longint'(1) << (sh - 1))) >>> sh : s;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    function automatic logic [64:0] expect_grp(input longint s[4], input int sh, input bit last);
        logic [64:0] e;
        e[64] = last;
        for (int i = 0; i < 4; i++) e[i*16 +: 16] = rq(s[i], sh);
        return e;
    endfunction

    function automatic logic [3:0][31:0] mk(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int k, input int n, input int sh);
        start = 1'b1;
        cfg_k_tiles = 8'(k);
        cfg_n_groups = 8'(n);
        cfg_shift = 5'(sh);
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0][31:0] v);
        valid_reduced = 1'b1;
        reduced_vec = v;
        tick();
        valid_reduced = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            ok = done;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({out_valid, out_last, busy, done, overflow_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=00000", {out_valid, out_last, busy, done, overflow_err});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic [3:0][31:0] v;
        longint s[4];
        logic [64:0] e;
        bit ok;
        got.delete();
        out_ready = 1'b1;
        start_job(3, 1, 0);
        v = mk(1, 2, 3, 4);
        for (int b = 0; b < 3; b++) beat(v);
        s = '{3, 6, 9, 12};
        e = expect_grp(s, 0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || {out_last, out_vec} !== e) begin
            errors++;
            $display("FAIL basic_latency valid=%b got=%h exp=%h", out_valid, {out_last, out_vec}, e);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got=%b exp=1", busy);
        end
        wait_done(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got=timeout exp=pulse");
        end
        checks++;
        if (got.size() != 1 || got[0] !== e) begin
            errors++;
            $display("FAIL basic_out count=%0d exp_count=1 exp=%h", got.size(), e);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse done=%b busy=%b exp=0 0", done, busy);
        end
    endtask

    task automatic test_round;
        logic [64:0] e;
        bit ok;
        got.delete();
        start_job(1, 1, 1);
        beat(mk(5, -5, 4, -3));
        e = {1'b1, 16'hFFFF, 16'd2, 16'hFFFE, 16'd3};
        checks++;
        if ({out_last, out_vec} !== e) begin
            errors++;
            $display("FAIL round got=%h exp=%h", {out_last, out_vec}, e);
        end
        wait_done(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL round_done got=timeout exp=pulse");
        end
    endtask

    task automatic test_sat;
        logic [64:0] e;
        bit ok;
        got.delete();
        start_job(2, 1, 0);
        beat(mk(20000, -20000, 32767, 0));
        beat(mk(20000, -20000, 32767, 0));
        e = {1'b1, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF};
        checks++;
        if ({out_last, out_vec} !== e) begin
            errors++;
            $display("FAIL saturate got=%h exp=%h", {out_last, out_vec}, e);
        end
        wait_done(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sat_done got=timeout exp=pulse");
        end
    endtask

    task automatic test_overflow;
        logic [64:0] exp[$];
        logic [3:0][31:0] v;
        longint s[4];
        logic [64:0] head;
        bit ok;
        got.delete();
        out_ready = 1'b0;
        start_job(1, 5, 0);
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = 32'(int'($urandom_range(0, 60000)) - 30000);
                s[i] = longint'($signed(v[i]));
            end
            if (g < 4) exp.push_back(expect_grp(s, 0, 1'b0));
            beat(v);
        end
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag got=%b exp=1", overflow_err);
        end
        head = {out_last, out_vec};
        checks++;
        if (out_valid !== 1'b1 || head !== exp[0]) begin
            errors++;
            $display("FAIL overflow_head valid=%b got=%h exp=%h", out_valid, head, exp[0]);
        end
        repeat (3) tick();
        checks++;
        if ({out_last, out_vec} !== exp[0] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable got=%h exp=%h busy=%b done=%b", {out_last, out_vec}, exp[0], busy, done);
        end
        out_ready = 1'b1;
        wait_done(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL overflow_done got=timeout exp=pulse");
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL overflow_count got=%0d exp=4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++;
                $display("FAIL overflow_entry%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 65'bx, exp[i]);
            end
        end
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got=%b exp=1", overflow_err);
        end
    endtask

    task automatic test_reset_mid;
        logic [64:0] e;
        bit ok;
        got.delete();
        start_job(4, 2, 0);
        beat(mk(9, 9, 9, 9));
        beat(mk(9, 9, 9, 9));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid, out_last, busy, done, overflow_err} !== 5'b0 || out_vec !== 64'b0) begin
            errors++;
            $display("FAIL reset_mid got=%b vec=%h exp=00000 0", {out_valid, out_last, busy, done, overflow_err}, out_vec);
        end
        start_job(1, 1, 0);
        beat(mk(7, 7, 7, 7));
        e = {1'b1, 16'd7, 16'd7, 16'd7, 16'd7};
        checks++;
        if ({out_last, out_vec} !== e) begin
            errors++;
            $display("FAIL reset_restart got=%h exp=%h", {out_last, out_vec}, e);
        end
        wait_done(10, ok);
        checks++;
        if (!ok || got.size() != 1) begin
            errors++;
            $display("FAIL reset_restart_done done=%b count=%0d exp=1 1", ok, got.size());
        end
    endtask

    task automatic test_edges;
        logic [64:0] e0, e1;
        bit ok;
        got.delete();
        start_job(1, 0, 0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL n0_cycle1 done=%b busy=%b exp=0 1", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL n0_done got=%b exp=1", done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || got.size() != 0) begin
            errors++;
            $display("FAIL n0_after done=%b busy=%b count=%0d exp=0 0 0", done, busy, got.size());
        end
        beat(mk(100, 100, 100, 100));
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || got.size() != 0) begin
            errors++;
            $display("FAIL idle_valid out_valid=%b busy=%b count=%0d exp=0 0 0", out_valid, busy, got.size());
        end
        start_job(0, 2, 0);
        beat(mk(11, -12, 13, -14));
        start_job(3, 1, 4);
        beat(mk(-1, 2, -3, 4));
        e0 = {1'b0, 16'hFFF2, 16'd13, 16'hFFF4, 16'd11};
        e1 = {1'b1, 16'd4, 16'hFFFD, 16'd2, 16'hFFFF};
        wait_done(10, ok);
        checks++;
        if (!ok || got.size() != 2) begin
            errors++;
            $display("FAIL k0_busy_start done=%b count=%0d exp=1 2", ok, got.size());
        end
        checks++;
        if (got.size() != 2 || got[0] !== e0 || got[1] !== e1) begin
            errors++;
            $display("FAIL k0_values count=%0d exp=%h %h", got.size(), e0, e1);
        end
    endtask

    task automatic test_random;
        logic [64:0] exp[$];
        logic [3:0][31:0] v;
        longint s[4];
        int k, n, sh, keff;
        bit ok;
        for (int j = 0; j < 8; j++) begin
            got.delete();
            exp.delete();
            k = int'($urandom_range(0, 4));
            n = int'($urandom_range(1, 4));
            sh = int'($urandom_range(0, 15));
            keff = (k == 0) ? 1 : k;
            start_job(k, n, sh);
            for (int g = 0; g < n; g++) begin
                s = '{0, 0, 0, 0};
                for (int b = 0; b < keff; b++) begin
                    repeat ($urandom_range(0, 2)) begin
                        out_ready = 1'($urandom_range(0, 1));
                        tick();
                    end
                    for (int i = 0; i < 4; i++) begin
                        v[i] = 32'(int'($urandom_range(0, 4194303)) - 2097152);
                        s[i] += longint'($signed(v[i]));
                    end
                    out_ready = 1'($urandom_range(0, 1));
                    beat(v);
                end
                exp.push_back(expect_grp(s, sh, g == n - 1));
            end
            out_ready = 1'b1;
            wait_done(50, ok);
            checks++;
            if (!ok || got.size() != exp.size()) begin
                errors++;
                $display("FAIL rand%0d_done done=%b count=%0d exp=%0d", j, ok, got.size(), exp.size());
            end
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (i >= got.size() || got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rand%0d_entry%0d got=%h exp=%h", j, i, (i < got.size()) ? got[i] : 65'bx, exp[i]);
                end
            end
            checks++;
            if (overflow_err !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_overflow got=%b exp=0", j, overflow_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        valid_reduced = 1'b0;
        out_ready = 1'b1;
        cfg_k_tiles = '0;
        cfg_n_groups = '0;
        cfg_shift = '0;
        reduced_vec = '0;
        test_reset();
        test_basic();
        test_round();
        test_sat();
        test_overflow();
        test_reset_mid();
        test_edges();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_accum_wb.md
Name: psum_accum_wb

Overview:
- Downstream consumer of the 4-array MAC pipeline's reduction output (valid_reduced / reduced_vec).
- Accumulates K tile partial sums per output row-block, requantizes each sum to OUT_WIDTH (round-shift, saturate), and queues the results in a small FIFO.
- Results leave through a valid/ready port toward the output buffer writer.
- The upstream has no backpressure, so overflow is detected and flagged, never stalled.

Parameters:
- TILE_SIZE, 4, vector lanes per beat
- ACC_WIDTH, 32, width of each incoming reduced_vec lane
- OUT_WIDTH, 16, width of each output lane (signed)
- KT_W, 8, width of the tile-count and group-count config fields
- FIFO_DEPTH, 4, output FIFO entries (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; latches config and begins a job
- cfg_k_tiles  in  KT_W  beats per output group (0 treated as 1)
- cfg_n_groups  in  KT_W  output groups per job
- cfg_shift  in  5  arithmetic right shift applied before saturation
- valid_reduced  in  1  reduced_vec beat valid
- reduced_vec  in  [TILE_SIZE][ACC_WIDTH] signed partial-sum vector
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_vec  out  [TILE_SIZE][OUT_WIDTH] signed requantized vector
- out_last  out  1  head is the final group of the job
- busy  out  1  high in ACCUM and DRAIN
- done  out  1  one-cycle pulse at job end
- overflow_err  out  1  sticky; a push was attempted into a full FIFO

Behaviour:
- Reset, synchronous and applied at any time including mid-job:
  - state=IDLE; accumulators, beat and group counters cleared; FIFO emptied.
  - out_valid, out_last, busy, done and overflow_err all 0.
- States:
  - IDLE: on start, latch the three config fields, clear the accumulators and go to ACCUM. If cfg_n_groups==0, go straight to DRAIN instead. overflow_err is cleared on start.
  - ACCUM: each valid_reduced adds reduced_vec into per-lane accumulators of width ACC_WIDTH+KT_W (sign-extended).
    - On the k-th beat the group result is computed from acc+current beat. It is pushed to the FIFO on that same edge and the accumulators clear to 0. The next beat starts a new group.
    - After group n_groups is pushed, go to DRAIN.
  - DRAIN: when the FIFO is empty, pulse done for one cycle and go to IDLE.
- valid_reduced is ignored in IDLE and DRAIN. start is ignored unless in IDLE.
- Requantize, per lane: if shift>0, r = (s + (1<<(shift-1))) >>> shift (round half up); else r = s. Then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Latency: the final beat of a group at edge t makes out_valid=1 in cycle t+1 when the FIFO was empty.
- FIFO:
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle are allowed when full; the entry count is unchanged.
  - out_vec and out_last hold stable while out_valid && !out_ready.
  - out_last is stored per entry; it is set on the group whose index equals n_groups-1.
- Overflow: a push into a full FIFO with no simultaneous pop drops the result and sets overflow_err. The group counter still advances, so the job still terminates.
- Accumulator guard bits (KT_W) guarantee no wrap for k ≤ 2^KT_W-1.

Decomposition:
- Package psum_accum_pkg holds:
  - typedef state_t {IDLE, ACCUM, DRAIN}
  - localparam ACC_EXT_W = ACC_WIDTH+KT_W
  - function sat_round(value, shift) returning OUT_WIDTH
- One sub-module: sync_fifo, parameterised by data width (TILE_SIZE*OUT_WIDTH+1) and depth. It provides push, pop, full, empty and dout, and is cleared by rst.

Test Plan:
- Basic accumulation: k=3, n=1, shift=0; three beats of [1,2,3,4]; out_ready=1 → single output [3,6,9,12] with out_last=1, one cycle after the third beat; done follows in the next cycle.
- Rounding: k=1, shift=1; lanes [5,-5,4,-3] → [3,-2,2,-1].
- Saturation: k=2, shift=0; two beats of [20000,-20000,32767,0] → [32767,-32768,32767,0].
- Overflow and backpressure: k=1, n=5, out_ready=0, five beats → overflow_err=1; FIFO holds groups 0–3. Then raise out_ready → four outputs in order, none flagged last, then done.
- Reset mid-job: k=4, n=2; reset after 2 beats → all outputs 0, FIFO empty. A new start with k=1, n=1 and beat [7,7,7,7] → [7,7,7,7] with out_last=1.
- Edge configs: n=0 → done exactly 2 cycles after start with no output. k=0 → behaves as k=1. start pulsed while busy → no effect. valid_reduced in IDLE → no effect.
